dynamic_branch_predictor: RTL and testbench

- Parametrised successor to the decode-stage static predictor.
- Holds a branch history table (BHT) of saturating counters, indexed by PC, and makes a taken/not-taken prediction in decode.
- Trains the table from resolved outcomes in execute and flags mispredictions, supplying the corrected PC.
- MODE selects dynamic prediction or the legacy static backward-taken/forward-not-taken rule, so the pipeline can swap predictors without port changes.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bht_table.sv | 37 +++
 rtl/dynamic_branch_predictor.sv | 92 +++++++++
 tb/tb_dynamic_branch_predictor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants and saturating-counter helpers for the branch predictor.
// Counters are carried in a 4-bit container and sliced to COUNTER_BITS by users.
package bp_pkg;

    localparam int MODE_STATIC  = 0;
    localparam int MODE_DYNAMIC = 1;

    localparam int CTR_MAX_W = 4;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    function automatic ctr_t ctr_max(input int bits);
        return ctr_t'((1 << bits) - 1);
    endfunction

    // Weakly-not-taken: MSB clear, every lower bit set.
    function automatic ctr_t ctr_reset(input int bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t v, input int bits);
        return (v >= ctr_max(bits)) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: saturating counters with one combinational read port
// and one synchronous saturating-update port.
module bht_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CW      = 2,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CW-1:0]    o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [CW-1:0] r_ctr [ENTRIES];
    ctr_t          w_cur;
    logic [CW-1:0] w_next;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = ctr_t'(r_ctr[i_wr_idx]);
    assign w_next   = CW'(i_wr_taken ? sat_inc(w_cur, CW) : sat_dec(w_cur));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CW'(ctr_reset(CW));
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_next;
        end
    end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Decode-stage taken/not-taken predictor with execute-stage training,
// misprediction redirect and resolved/mispredicted statistics.
module dynamic_branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int COUNTER_BITS = 2,
    parameter int MODE         = 1,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Branch_d,
    input  logic [DATA_WIDTH-1:0] PC_d,
    input  logic [DATA_WIDTH-1:0] ImmExt_d,
    input  logic                  Branch_e,
    input  logic                  EQ,
    input  logic [DATA_WIDTH-1:0] PC_e,
    input  logic [DATA_WIDTH-1:0] ImmExt_e,
    input  logic [DATA_WIDTH-1:0] PCPlus4_e,
    input  logic                  predicted_e,
    input  logic                  stall_e,
    output logic                  predict_taken,
    output logic [DATA_WIDTH-1:0] predict_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] correct_PC,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_rule_taken;
    logic                  w_train;
    logic                  w_mispredict;
    logic [STAT_WIDTH-1:0] r_branch_count;
    logic [STAT_WIDTH-1:0] r_mispredict_count;

    assign w_target = PC_d + ImmExt_d;
    assign w_train  = Branch_e & ~stall_e;

    generate
        if (MODE == MODE_DYNAMIC) begin : g_dyn
            logic [COUNTER_BITS-1:0] w_rd_ctr;

            bht_table #(
                .ENTRIES (BHT_ENTRIES),
                .CW      (COUNTER_BITS)
            ) u_bht (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_rd_idx   (PC_d[IDX_W+1:2]),
                .o_rd_ctr   (w_rd_ctr),
                .i_wr_en    (w_train),
                .i_wr_idx   (PC_e[IDX_W+1:2]),
                .i_wr_taken (EQ)
            );

            assign w_rule_taken = w_rd_ctr[COUNTER_BITS-1];
        end else begin : g_static
            // Backward branches (target below PC) are assumed to be loops.
            assign w_rule_taken = (w_target < PC_d);
        end
    endgenerate

    assign predict_taken  = Branch_d & w_rule_taken;
    assign predict_target = w_target;

    assign w_mispredict = w_train & (EQ != predicted_e);
    assign mispredict   = w_mispredict;
    assign correct_PC   = (Branch_e & EQ) ? PC_e + ImmExt_e : PCPlus4_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_train) begin
            if (r_branch_count != '1) begin
                r_branch_count <= r_branch_count + STAT_WIDTH'(1);
            end
            if (w_mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + STAT_WIDTH'(1);
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Bench for dynamic_branch_predictor: a dynamic and a static instance share stimulus,
// checked against fixed vectors, hand sequences and a counter-array reference model.
module tb_dynamic_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        Branch_d;
    logic [31:0] PC_d;
    logic [31:0] ImmExt_d;
    logic        Branch_e;
    logic        EQ;
    logic [31:0] PC_e;
    logic [31:0] ImmExt_e;
    logic [31:0] PCPlus4_e;
    logic        predicted_e;
    logic        stall_e;

    logic        d_taken, s_taken;
    logic [31:0] d_target, s_target;
    logic        d_misp, s_misp;
    logic [31:0] d_cpc, s_cpc;
    logic [31:0] d_bc, s_bc;
    logic [31:0] d_mc, s_mc;

    int n_checks = 0;
    int n_err    = 0;

    int    m_ctr [64];
    longint m_bc;
    longint m_mc;
    localparam longint STAT_MAX = 64'hFFFF_FFFF;

    dynamic_branch_predictor #(.MODE(1)) u_dyn (
        .clk(clk), .rst_n(rst_n),
        .Branch_d(Branch_d), .PC_d(PC_d), .ImmExt_d(ImmExt_d),
        .Branch_e(Branch_e), .EQ(EQ), .PC_e(PC_e), .ImmExt_e(ImmExt_e),
        .PCPlus4_e(PCPlus4_e), .predicted_e(predicted_e), .stall_e(stall_e),
        .predict_taken(d_taken), .predict_target(d_target),
        .mispredict(d_misp), .correct_PC(d_cpc),
        .branch_count(d_bc), .mispredict_count(d_mc)
    );

    dynamic_branch_predictor #(.MODE(0)) u_sta (
        .clk(clk), .rst_n(rst_n),
        .Branch_d(Branch_d), .PC_d(PC_d), .ImmExt_d(ImmExt_d),
        .Branch_e(Branch_e), .EQ(EQ), .PC_e(PC_e), .ImmExt_e(ImmExt_e),
        .PCPlus4_e(PCPlus4_e), .predicted_e(predicted_e), .stall_e(stall_e),
        .predict_taken(s_taken), .predict_target(s_target),
        .mispredict(s_misp), .correct_PC(s_cpc),
        .branch_count(s_bc), .mispredict_count(s_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bd;
        logic [31:0] pcd;
        logic [31:0] immd;
        logic        be;
        logic        eq;
        logic [31:0] pce;
        logic [31:0] imme;
        logic [31:0] pc4;
        logic        pred;
        logic        stall;
        logic        x_dyn;
        logic        x_sta;
        logic [31:0] x_tgt;
        logic        x_misp;
        logic [31:0] x_cpc;
        logic [31:0] x_bc;
        logic [31:0] x_mc;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic drive(input logic bd, input logic [31:0] pcd, input logic [31:0] immd,
                         input logic be, input logic eq, input logic [31:0] pce,
                         input logic [31:0] imme, input logic [31:0] pc4,
                         input logic pred, input logic stall);
        Branch_d    = bd;
        PC_d        = pcd;
        ImmExt_d    = immd;
        Branch_e    = be;
        EQ          = eq;
        PC_e        = pce;
        ImmExt_e    = imme;
        PCPlus4_e   = pc4;
        predicted_e = pred;
        stall_e     = stall;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] tgt;
        logic [31:0] cpc;
        logic        misp;
        tgt  = PC_d + ImmExt_d;
        misp = Branch_e && !stall_e && (EQ != predicted_e);
        cpc  = (Branch_e && EQ) ? PC_e + ImmExt_e : PCPlus4_e;
        chk({tag, " dyn_taken"}, d_taken, Branch_d && (m_ctr[idx(PC_d)] >= 2));
        chk({tag, " sta_taken"}, s_taken, Branch_d && (tgt < PC_d));
        chk({tag, " target"}, d_target, tgt);
        chk({tag, " sta_target"}, s_target, tgt);
        chk({tag, " misp"}, d_misp, misp);
        chk({tag, " sta_misp"}, s_misp, misp);
        chk({tag, " cpc"}, d_cpc, cpc);
        chk({tag, " sta_cpc"}, s_cpc, cpc);
        chk({tag, " bc"}, d_bc, m_bc);
        chk({tag, " mc"}, d_mc, m_mc);
        chk({tag, " sta_bc"}, s_bc, m_bc);
        chk({tag, " sta_mc"}, s_mc, m_mc);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && Branch_e && !stall_e) begin
            int i;
            i = idx(PC_e);
            if (m_bc < STAT_MAX) m_bc++;
            if (EQ != predicted_e && m_mc < STAT_MAX) m_mc++;
            if (EQ) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic eq);
        drive(1'b1, 32'h100, 32'h20, 1'b1, eq, pc, 32'h8, pc + 32'd4, 1'b0, 1'b0);
        check_model("seq");
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h104, 1'b0, 1'b0,
                   1'b0, 1'b0, 32'h120, 1'b0, 32'h104, 32'd0, 32'd0};
        tbl[1] = '{1'b1, 32'h100, 32'h20, 1'b1, 1'b1, 32'h100, 32'h8, 32'h104, 1'b0, 1'b0,
                   1'b0, 1'b0, 32'h120, 1'b1, 32'h108, 32'd0, 32'd0};
        tbl[2] = '{1'b1, 32'h100, 32'h20, 1'b1, 1'b1, 32'h100, 32'h8, 32'h104, 1'b0, 1'b0,
                   1'b1, 1'b0, 32'h120, 1'b1, 32'h108, 32'd1, 32'd1};
        tbl[3] = '{1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h100, 32'h8, 32'h104, 1'b0, 1'b0,
                   1'b1, 1'b0, 32'h120, 1'b0, 32'h104, 32'd2, 32'd2};
        tbl[4] = '{1'b0, 32'h100, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h100, 32'h8, 32'h104, 1'b0, 1'b0,
                   1'b0, 1'b0, 32'hF0, 1'b0, 32'h104, 32'd2, 32'd2};
        tbl[5] = '{1'b1, 32'h200, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h200, 32'h10, 32'h204, 1'b1, 1'b0,
                   1'b1, 1'b1, 32'h1F0, 1'b0, 32'h210, 32'd2, 32'd2};
        tbl[6] = '{1'b1, 32'h200, 32'h10, 1'b1, 1'b0, 32'h200, 32'h10, 32'h204, 1'b0, 1'b0,
                   1'b1, 1'b0, 32'h210, 1'b0, 32'h204, 32'd3, 32'd2};

        rst_n = 1'b0;
        model_reset();
        drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        #1;
        chk("reset bc", d_bc, 32'd0);
        chk("reset mc", d_mc, 32'd0);
        chk("reset taken", d_taken, 1'b0);
        chk("reset target", d_target, 32'h120);
        #9;
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            drive(tbl[k].bd, tbl[k].pcd, tbl[k].immd, tbl[k].be, tbl[k].eq,
                  tbl[k].pce, tbl[k].imme, tbl[k].pc4, tbl[k].pred, tbl[k].stall);
            chk($sformatf("vec%0d dyn_taken", k), d_taken, tbl[k].x_dyn);
            chk($sformatf("vec%0d sta_taken", k), s_taken, tbl[k].x_sta);
            chk($sformatf("vec%0d target", k), d_target, tbl[k].x_tgt);
            chk($sformatf("vec%0d misp", k), d_misp, tbl[k].x_misp);
            chk($sformatf("vec%0d cpc", k), d_cpc, tbl[k].x_cpc);
            chk($sformatf("vec%0d bc", k), d_bc, tbl[k].x_bc);
            chk($sformatf("vec%0d mc", k), d_mc, tbl[k].x_mc);
            chk($sformatf("vec%0d sta_bc", k), s_bc, tbl[k].x_bc);
            tick();
        end

        // Counter at index 0 is 10; six not-taken resolves saturate it at 00.
        for (int k = 0; k < 6; k++) resolve(32'h100, 1'b0);
        resolve(32'h100, 1'b1);
        drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        chk("sat floor then inc", d_taken, 1'b0);

        drive(1'b1, 32'h100, 32'h20, 1'b1, 1'b1, 32'h100, 32'h8, 32'h104, 1'b0, 1'b0);
        chk("same-cycle old", d_taken, 1'b0);
        tick();
        drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        chk("same-cycle new", d_taken, 1'b1);

        drive(1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 32'h100, 32'h8, 32'h104, 1'b1, 1'b1);
        chk("stall misp", d_misp, 1'b0);
        tick();
        drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        chk("stall no train", d_taken, 1'b1);
        check_model("stall");

        resolve(32'h200, 1'b0);
        drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        chk("alias down", d_taken, 1'b0);
        resolve(32'h200, 1'b1);
        resolve(32'h200, 1'b1);
        drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        chk("alias up", d_taken, 1'b1);

        // Mid-run reset, away from any clock edge.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst taken", d_taken, 1'b0);
        chk("midrst bc", d_bc, 32'd0);
        chk("midrst mc", d_mc, 32'd0);
        chk("midrst sta_bc", s_bc, 32'd0);
        drive(1'b1, 32'h100, 32'h20, 1'b1, 1'b1, 32'h100, 32'h8, 32'h104, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst no train", d_taken, 1'b0);
        chk("rst no stat", d_bc, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        check_model("post rst");
        tick();

        for (int k = 0; k < 1500; k++) begin
            drive(1'($urandom), ($urandom_range(0, 255) << 2) | 32'($urandom_range(0, 3)),
                  $urandom, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 255) << 2, $urandom, $urandom,
                  1'($urandom), ($urandom_range(0, 3) == 0));
            check_model("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
